board_input_cond: RTL and testbench

BOARD_INPUT_COND -- requirements
Module: board_input_cond

---
 rtl/board_input_cond.sv | 98 +++++++++
 tb/tb_board_input_cond.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/board_input_cond.sv
// Board input conditioner: per-channel synchroniser, counter debouncer,
// edge pulses and sticky maskable event flags with a combined interrupt.
module board_input_cond #(
  parameter int              N_CH        = 8,
  parameter int              SYNC_STAGES = 2,
  parameter int              DB_CYCLES   = 16000,
  parameter logic [N_CH-1:0] INIT_VAL    = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [N_CH-1:0] in_raw,
  input  logic [N_CH-1:0] rise_en,
  input  logic [N_CH-1:0] fall_en,
  input  logic [N_CH-1:0] evt_mask,
  input  logic [N_CH-1:0] evt_clr,
  output logic [N_CH-1:0] in_db,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o,
  output logic [N_CH-1:0] evt_pend,
  output logic            irq_o
);

  localparam int            CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [N_CH-1:0] sync_r [SYNC_STAGES];
  logic [N_CH-1:0] sync_s;
  logic [CW-1:0]   cnt_r     [N_CH];
  logic [CW-1:0]   cnt_nxt_s [N_CH];
  logic [N_CH-1:0] in_db_r;
  logic [N_CH-1:0] rise_r;
  logic [N_CH-1:0] fall_r;
  logic [N_CH-1:0] pend_r;
  logic [N_CH-1:0] upd_s;
  logic [N_CH-1:0] rise_nxt_s;
  logic [N_CH-1:0] fall_nxt_s;
  logic [N_CH-1:0] pend_nxt_s;

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Synchroniser chain; resets to INIT_VAL so release never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_r[k] <= INIT_VAL;
    end else begin
      sync_r[0] <= in_raw;
      for (int k = 1; k < SYNC_STAGES; k++) sync_r[k] <= sync_r[k-1];
    end
  end

  // Debounce qualification: count while the synced level differs, accept on the last count.
  always_comb begin
    upd_s = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      cnt_nxt_s[i] = {CW{1'b0}};
      if (en && (sync_s[i] != in_db_r[i])) begin
        if (cnt_r[i] == CNT_LAST) begin
          upd_s[i]     = 1'b1;
          cnt_nxt_s[i] = {CW{1'b0}};
        end else begin
          cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
        end
      end else begin
        cnt_nxt_s[i] = {CW{1'b0}};
      end
    end
    rise_nxt_s = upd_s & sync_s;
    fall_nxt_s = upd_s & ~sync_s;
    // A new event outranks a same-cycle clear so it is never lost.
    pend_nxt_s = (pend_r & ~evt_clr) | (rise_nxt_s & rise_en) | (fall_nxt_s & fall_en);
  end

  // Debounced level, edge pulses, counters and pending flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) cnt_r[i] <= {CW{1'b0}};
      in_db_r <= INIT_VAL;
      rise_r  <= {N_CH{1'b0}};
      fall_r  <= {N_CH{1'b0}};
      pend_r  <= {N_CH{1'b0}};
    end else begin
      for (int i = 0; i < N_CH; i++) cnt_r[i] <= cnt_nxt_s[i];
      in_db_r <= in_db_r ^ upd_s;
      rise_r  <= rise_nxt_s;
      fall_r  <= fall_nxt_s;
      pend_r  <= pend_nxt_s;
    end
  end

  assign in_db    = in_db_r;
  assign rise_o   = rise_r;
  assign fall_o   = fall_r;
  assign evt_pend = pend_r;
  assign irq_o    = |(pend_r & evt_mask);

endmodule

// File: tb/tb_board_input_cond.sv
// Directed self-checking bench for board_input_cond (4 channels, 4-cycle debounce)
// plus a 1-channel instance with a single-cycle debounce and a high reset level.
module tb_board_input_cond;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] in_raw, rise_en, fall_en, evt_mask, evt_clr;
  logic [3:0] in_db, rise_o, fall_o, evt_pend;
  logic       irq_o;
  logic       in_raw1;
  logic       in_db1, rise1, fall1, pend1, irq1;
  logic [3:0] pulse_acc;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  board_input_cond #(.N_CH(4), .SYNC_STAGES(2), .DB_CYCLES(4), .INIT_VAL(4'h0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_raw(in_raw), .rise_en(rise_en),
    .fall_en(fall_en), .evt_mask(evt_mask), .evt_clr(evt_clr), .in_db(in_db),
    .rise_o(rise_o), .fall_o(fall_o), .evt_pend(evt_pend), .irq_o(irq_o)
  );

  board_input_cond #(.N_CH(1), .SYNC_STAGES(3), .DB_CYCLES(1), .INIT_VAL(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_raw(in_raw1), .rise_en(1'b1),
    .fall_en(1'b1), .evt_mask(1'b1), .evt_clr(1'b0), .in_db(in_db1),
    .rise_o(rise1), .fall_o(fall1), .evt_pend(pend1), .irq_o(irq1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      pulse_acc = pulse_acc | rise_o | fall_o;
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; in_raw = 4'h0; in_raw1 = 1'b1;
    rise_en = 4'h0; fall_en = 4'h0; evt_mask = 4'h0; evt_clr = 4'h0;
    pulse_acc = 4'h0;
    tick(2);
    chk("rst_in_db", 32'(in_db), 32'h0);
    chk("rst_pulses", 32'({rise_o, fall_o}), 32'h0);
    chk("rst_pend", 32'(evt_pend), 32'h0);
    chk("rst_irq", 32'(irq_o), 32'h0);
    chk("rst_in_db1", 32'(in_db1), 32'h1);
    rst_n = 1'b1;
    tick(3);
    chk("no_spurious_after_rst", 32'({in_db, rise_o, fall_o, evt_pend}), 32'h0);

    // Clean press on ch0
    en = 1'b1; rise_en = 4'hF; evt_mask = 4'h1;
    in_raw = 4'h1;
    tick(5);
    chk("press_edge5_in_db", 32'(in_db), 32'h0);
    tick(1);
    chk("press_edge6_in_db", 32'(in_db), 32'h1);
    chk("press_rise", 32'(rise_o), 32'h1);
    chk("press_pend", 32'(evt_pend), 32'h1);
    chk("press_irq", 32'(irq_o), 32'h1);
    tick(1);
    chk("press_rise_1cyc", 32'(rise_o), 32'h0);
    chk("press_hold", 32'(in_db), 32'h1);

    // Single-cycle debounce instance: 3 sync edges + 1
    in_raw1 = 1'b0;
    tick(3);
    chk("db1_edge3", 32'(in_db1), 32'h1);
    tick(1);
    chk("db1_edge4", 32'({in_db1, fall1, pend1, irq1}), 32'b0111);

    // Set/clear collision on ch0
    evt_clr = 4'hF; tick(1); evt_clr = 4'h0;
    chk("clr_pend", 32'(evt_pend), 32'h0);
    in_raw = 4'h0;
    tick(6);
    chk("ch0_fall", 32'({in_db, fall_o, evt_pend}), 32'h010);
    in_raw = 4'h1;
    tick(5);
    evt_clr = 4'h1;
    tick(1);
    chk("coll_rise", 32'(rise_o), 32'h1);
    chk("coll_set_wins", 32'(evt_pend), 32'h1);
    tick(1);
    evt_clr = 4'h0;
    chk("coll_clear", 32'(evt_pend), 32'h0);
    chk("coll_irq", 32'(irq_o), 32'h0);

    // Bounce on ch1: 3 high, 1 low, 3 high, then low
    pulse_acc = 4'h0;
    in_raw[1] = 1'b1; tick(3);
    in_raw[1] = 1'b0; tick(1);
    in_raw[1] = 1'b1; tick(3);
    in_raw[1] = 1'b0; tick(10);
    chk("bounce_in_db", 32'(in_db), 32'h1);
    chk("bounce_no_pulse", 32'(pulse_acc), 32'h0);
    in_raw[1] = 1'b1;
    tick(5);
    chk("held_edge5", 32'(in_db), 32'h1);
    tick(1);
    chk("held_edge6", 32'({in_db, rise_o}), 32'h32);
    in_raw[1] = 1'b0;
    tick(6);
    chk("ch1_back_low", 32'({in_db, fall_o}), 32'h12);

    // Masking and fall events on ch2
    rise_en = 4'hB; fall_en = 4'h4; evt_mask = 4'h1;
    evt_clr = 4'hF; tick(1); evt_clr = 4'h0;
    in_raw[2] = 1'b1;
    tick(6);
    chk("ch2_rise", 32'(rise_o), 32'h4);
    chk("ch2_rise_no_pend", 32'(evt_pend), 32'h0);
    tick(4);
    in_raw[2] = 1'b0;
    tick(6);
    chk("ch2_fall", 32'(fall_o), 32'h4);
    chk("ch2_fall_pend", 32'(evt_pend), 32'h4);
    chk("ch2_masked_irq", 32'(irq_o), 32'h0);
    tick(4);
    evt_mask = 4'h4; #1;
    chk("ch2_unmask_irq", 32'(irq_o), 32'h1);
    chk("mask_keeps_pend", 32'(evt_pend), 32'h4);

    // Enable gating
    fall_en = 4'hF; in_raw = 4'h0;
    tick(6);
    chk("all_low", 32'({in_db, evt_pend}), 32'h05);
    en = 1'b0; in_raw = 4'hF; pulse_acc = 4'h0;
    evt_clr = 4'hF; tick(1); evt_clr = 4'h0;
    chk("dis_clr_pend", 32'(evt_pend), 32'h0);
    tick(19);
    chk("dis_in_db", 32'(in_db), 32'h0);
    chk("dis_no_pulse", 32'(pulse_acc), 32'h0);
    en = 1'b1;
    tick(3);
    chk("en_edge3", 32'(in_db), 32'h0);
    tick(1);
    chk("en_edge4", 32'({in_db, rise_o}), 32'hFF);

    // Reset mid-qualification on ch3
    in_raw = 4'h0;
    tick(6);
    chk("pre_rst_low", 32'(in_db), 32'h0);
    in_raw[3] = 1'b1;
    tick(5);
    rst_n = 1'b0; #1;
    chk("midrst_outputs", 32'({in_db, rise_o, fall_o, evt_pend}), 32'h0);
    chk("midrst_irq", 32'(irq_o), 32'h0);
    #3 rst_n = 1'b1;
    tick(5);
    chk("after_rst_edge5", 32'(in_db), 32'h0);
    tick(1);
    chk("after_rst_edge6", 32'(in_db), 32'h8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
